// File: rtl/fdiv_sched_pkg.sv
// fdiv_sched_pkg: shared constants and tag type for the divider scheduler
// FDIV_LAT: divider pipeline depth; ID_W: requester id width for up to NREQ_MAX requesters
package fdiv_sched_pkg;
  localparam int FDIV_LAT = 4;
  localparam int NREQ_MAX = 4;
  localparam int ID_W = $clog2(NREQ_MAX);
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/fdiv_sched_if.sv
// fdiv_sched_if: requester-side bundle of the divider scheduler
// req_valid/req_ready/req_a/req_b: issue handshake and operands, 32 bits per requester
// rsp_valid/rsp_ready/rsp_data: per-requester result handshake and quotient
// busy: scheduler has work in flight or unconsumed results
interface fdiv_sched_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  logic [32*NREQ-1:0] rsp_data;
  logic busy;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fdiv.sv
// fdiv: pipelined single-precision divider, fixed LAT-cycle latency, no stall, no reset
// clk: clock; en: issue strobe; a/b: dividend/divisor; c: quotient; ready: c valid
// Round to nearest even; denormal inputs and tiny results flush to signed zero
module fdiv
  import fdiv_sched_pkg::*;
#(parameter int LAT = FDIV_LAT) (
  input  logic clk,
  input  logic en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c,
  output logic ready
);
  logic za, zb, ia, ib, nan, s, hi, g, st, up;
  logic [48:0] num, den, rem;
  logic [25:0] quo;
  logic [23:0] man;
  logic [24:0] rnd;
  logic signed [9:0] ex, exr;
  logic [31:0] fin, q;
  logic [31:0] pipe [LAT];
  logic [LAT-1:0] vld;
  assign s = a[31] ^ b[31];
  assign za = a[30:23] == 8'd0;
  assign zb = b[30:23] == 8'd0;
  assign ia = a[30:23] == 8'hFF;
  assign ib = b[30:23] == 8'hFF;
  assign nan = (ia & |a[22:0]) | (ib & |b[22:0]) | (za & zb) | (ia & ib);
  // 24-bit mantissa ratio lies in (0.5, 2): 26 quotient bits leave a guard bit, remainder is sticky
  assign num = {1'b1, a[22:0], 25'd0};
  assign den = {25'd0, 1'b1, b[22:0]};
  assign quo = 26'(num / den);
  assign rem = num % den;
  assign hi = quo[25];
  assign man = hi ? quo[25:2] : quo[24:1];
  assign g = hi ? quo[1] : quo[0];
  assign st = (hi & quo[0]) | (|rem);
  assign rnd = {1'b0, man} + {24'd0, g & (st | man[0])};
  assign up = rnd[24];
  assign ex = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd126 + $signed({9'd0, hi});
  assign exr = ex + $signed({9'd0, up});
  assign fin = exr > 10'sd254 ? {s, 8'hFF, 23'd0} :
               exr < 10'sd1   ? {s, 31'd0} :
               {s, exr[7:0], up ? rnd[23:1] : rnd[22:0]};
  assign q = nan ? 32'h7FC00000 : (ia | zb) ? {s, 8'hFF, 23'd0} : (za | ib) ? {s, 31'd0} : fin;
  always_ff @(posedge clk) begin
    pipe[0] <= q;
    vld[0] <= en;
    for (int k = 1; k < LAT; k++) begin
      pipe[k] <= pipe[k-1];
      vld[k] <= vld[k-1];
    end
  end
  assign c = pipe[LAT-1];
  assign ready = vld[LAT-1];
endmodule

// File: rtl/fdiv_sched_arb.sv
// fdiv_sched_arb: picks at most one eligible requester per cycle
// elig: eligible requesters; grant: one-hot winner; win: winner index (0 when none)
// FDIV_SCHED_RR_EN: round-robin from a pointer (clk/rst_n present); otherwise lowest index wins
module fdiv_sched_arb
  import fdiv_sched_pkg::*;
#(parameter int NREQ = 2) (
`ifdef FDIV_SCHED_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] win
);
`ifdef FDIV_SCHED_RR_EN
  logic [ID_W-1:0] ptr;
  // scanning downward lets the candidate closest to ptr overwrite the others
  always_comb begin
    grant = '0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % NREQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        win = ID_W'((int'(ptr) + k) % NREQ);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (|grant) ptr <= ID_W'((int'(win) + 1) % NREQ);
`else
  always_comb begin
    grant = '0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (elig[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        win = ID_W'(k);
      end
  end
`endif
endmodule

// File: rtl/fdiv_sched.sv
// fdiv_sched: shares one pipelined fdiv among NREQ requesters with per-requester response registers
// clk: clock; rst_n: async active-low reset; bus: fdiv_sched_if slave (requests, responses, busy)
// FDIV_SCHED_RR_EN: round-robin arbitration when defined, fixed priority otherwise
module fdiv_sched
  import fdiv_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT = FDIV_LAT
) (
  input logic clk,
  input logic rst_n,
  fdiv_sched_if.slave bus
);
  logic [NREQ-1:0] outstanding, elig, grant, rsp_valid;
  logic [32*NREQ-1:0] rsp_data;
  logic [ID_W-1:0] win;
  logic [31:0] a, b, c;
  logic en, ready, inflight;
  tag_t tags [LAT];
  assign elig = bus.req_valid & ~outstanding;
  fdiv_sched_arb #(.NREQ(NREQ)) u_arb (
`ifdef FDIV_SCHED_RR_EN
    .clk(clk),
    .rst_n(rst_n),
`endif
    .elig(elig),
    .grant(grant),
    .win(win)
  );
  assign en = |grant;
  assign a = bus.req_a[32*int'(win) +: 32];
  assign b = bus.req_b[32*int'(win) +: 32];
  fdiv #(.LAT(LAT)) u_fdiv (
    .clk(clk),
    .en(en),
    .a(a),
    .b(b),
    .c(c),
    .ready(ready)
  );
  // the divider has no reset, so its ready is only cross-checked, never used to write results
  assert property (@(posedge clk) disable iff (!rst_n) tags[LAT-1].valid |-> ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tags <= '{default: '0};
    else begin
      tags[0] <= '{valid: en, id: win};
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outstanding <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) outstanding[i] <= 1'b1;
        else if (rsp_valid[i] & bus.rsp_ready[i]) outstanding[i] <= 1'b0;
        if (tags[LAT-1].valid && tags[LAT-1].id == ID_W'(i)) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[32*i +: 32] <= c;
        end else if (rsp_valid[i] & bus.rsp_ready[i]) rsp_valid[i] <= 1'b0;
      end
  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k < LAT; k++) inflight = inflight | tags[k].valid;
  end
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data = rsp_data;
  assign bus.busy = inflight | (|rsp_valid);
endmodule
